rv32_gpio_io: RTL and testbench
===============================

// Module: rv32_gpio_io
// PURPOSE
//  Parametrised memory-mapped GPIO block on the rv32 io bus; replaces the fixed 8-LED/1-button io top.
//  Drives NUM_LED output bits and samples NUM_BTN button inputs.
//  Each button has a synchroniser and debouncer, plus sticky rising-edge capture.
//  Edge capture has per-button interrupt enables, combined into one level irq for the core.
// PARAMETERS
//  BASE_ADDR    32'h80000000  byte base of the 32-byte register window; [4:0] must be 0
//  NUM_LED      8             LED output width, 1..32
//  NUM_BTN      4             button input count, 1..32
//  DEBOUNCE_CYC 16'd50000     cycles an input must hold a new level before it is accepted, >=2
//  LED_RST      0             LED_OUT reset value, NUM_LED bits
// PORTS
//  clk       in   1        system clock; all logic on rising edge
//  reset     in   1        asynchronous, active-low reset
//  io_addr   in   30       word address, io_addr[31:2]
//  io_rdata  out  32       read data, combinational from io_addr
//  io_we     in   1        write strobe, one cycle per write
//  io_be     in   4        byte enables for writes
//  io_wdata  in   32       write data
//  btn_in    in   NUM_BTN  raw asynchronous button levels, 1 = pressed
//  led_out   out  NUM_LED  LED drive, = LED_OUT register
//  irq       out  1        registered: |(BTN_EDGE & BTN_IE)
// BEHAVIOUR
//  Decode: hit when io_addr[31:5] == BASE_ADDR[31:5]; offset = io_addr[4:2].
//  Register map (offset: name, access):
//   0 LED_OUT  RW   byte-enabled write; bits >= NUM_LED read 0
//   1 LED_TGL  WO   write-1-to-toggle LED_OUT (byte-enabled); reads 0
//   2 BTN_LVL  RO   debounced level per button
//   3 BTN_EDGE W1C  sticky rising edge of the debounced level
//   4 BTN_IE   RW   interrupt enable per button
//   5-7           reads 0; writes ignored
//  Miss, or io_we=0: no state change.
//  io_rdata = 0 on miss.
//  Unimplemented upper bits read 0.
//  Reads have no side effects.
//  Writes take effect at the clock edge where io_we=1; read-after-write sees new data next cycle.
//  io_be gating: byte k of a register updates only when io_be[k]=1. This applies to RW, W1C and W1T.
//  Debounce per button:
//   - 2-FF synchroniser feeds sync.
//   - sync == stable: counter cleared.
//   - Otherwise counter increments; when it reaches DEBOUNCE_CYC-1, stable <= sync and counter clears.
//   - A glitch shorter than DEBOUNCE_CYC cycles never changes stable.
//   - Worst-case latency, pin to BTN_LVL: 2 + DEBOUNCE_CYC cycles.
//  Edge capture:
//   - rise = stable_next & ~stable.
//   - Set-wins: a rise in the same cycle as a W1C of that bit leaves the bit 1.
//   - Falling edges are not captured.
//  irq is registered one cycle after BTN_EDGE/BTN_IE change, then held until cleared or disabled.
//  Reset (async assert, sync-released use of state):
//   - LED_OUT=LED_RST; BTN_EDGE=0; BTN_IE=0; irq=0.
//   - Synchronisers, stable and counters = 0.
//   - Reset mid-debounce discards the pending transition.
//   - A button held at release is seen as a rise after debounce.
// STRUCTURE
//  Shared package rv32_io_pkg:
//   - register offset localparams (GPIO_LED_OUT=3'd0 .. GPIO_BTN_IE=3'd4)
//   - IO_BASE_GPIO = 32'h80000000
//  Sub-module rv32_btn_debounce:
//   - params WIDTH, DEBOUNCE_CYC; ports clk, reset, d_in, level, rise
//   - one instance with WIDTH=NUM_BTN, generate loop inside
//  Top holds decode, register file, read mux, irq flop.
// TESTING
//  1 Reset: assert reset=0 mid-run -> led_out=LED_RST, irq=0, BTN_EDGE and BTN_IE read 32'h0 immediately.
//  2 LED byte writes: write 0x80000000 data 32'hA5 be=4'b0001 -> led_out=8'hA5; write LED_TGL 32'h0F -> led_out=8'hAA; be=4'b0000 -> no change.
//  3 Debounce (DEBOUNCE_CYC=8): 5-cycle pulse on btn_in[1] -> BTN_LVL stays 0; 12-cycle hold -> BTN_LVL=4'b0010 within 10 cycles, BTN_EDGE[1]=1.
//  4 IRQ: BTN_IE=4'b0010 with BTN_EDGE[1]=1 -> irq=1 next cycle; W1C 32'h2 to offset 3 -> BTN_EDGE=0, irq=0 next cycle.
//  5 Set-wins: W1C of bit 1 in the same cycle as a debounced rise on button 1 -> BTN_EDGE[1]=1.
//  6 Decode: read/write at 0x80000014..1C and 0x80000020 -> rdata=0, no state change; NUM_LED=3 reads LED_OUT[31:3]=0.

Source files
------------

// File: rtl/rv32_io_pkg.sv
// Shared definitions for the rv32 io bus peripherals: base addresses and the
// GPIO register offsets within its 32-byte window.
package rv32_io_pkg;

  localparam logic [31:0] IO_BASE_GPIO = 32'h8000_0000;

  localparam logic [2:0] GPIO_LED_OUT  = 3'd0;
  localparam logic [2:0] GPIO_LED_TGL  = 3'd1;
  localparam logic [2:0] GPIO_BTN_LVL  = 3'd2;
  localparam logic [2:0] GPIO_BTN_EDGE = 3'd3;
  localparam logic [2:0] GPIO_BTN_IE   = 3'd4;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/rv32_btn_debounce.sv
// Per-button 2-FF synchroniser and hold-time debouncer; rise pulses in the
// cycle before the debounced level goes high.
module rv32_btn_debounce #(
  parameter int unsigned WIDTH        = 4,
  parameter logic [15:0] DEBOUNCE_CYC = 16'd50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_btn
    logic        meta_q, sync_q, stable_q, stable_d;
    logic [15:0] cnt_q, cnt_d;

    // Any return of sync to the stable level restarts the hold count.
    always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync_q != stable_q) begin
        if (cnt_q == DEBOUNCE_CYC - 16'd1) stable_d = sync_q;
        else                               cnt_d    = cnt_q + 16'd1;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        meta_q   <= 1'b0;
        sync_q   <= 1'b0;
        stable_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        meta_q   <= d_in[g];
        sync_q   <= meta_q;
        stable_q <= stable_d;
        cnt_q    <= cnt_d;
      end
    end

    assign level[g] = stable_q;
    assign rise[g]  = stable_d & ~stable_q;
  end

endmodule

// File: rtl/rv32_gpio_io.sv
// Memory-mapped GPIO: LED output/toggle registers, debounced button levels,
// sticky rising-edge capture with per-button interrupt enables.
module rv32_gpio_io
  import rv32_io_pkg::*;
#(
  parameter logic [31:0]         BASE_ADDR    = IO_BASE_GPIO,
  parameter int unsigned         NUM_LED      = 8,
  parameter int unsigned         NUM_BTN      = 4,
  parameter logic [15:0]         DEBOUNCE_CYC = 16'd50000,
  parameter logic [NUM_LED-1:0]  LED_RST      = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [29:0]        io_addr,
  output logic [31:0]        io_rdata,
  input  logic               io_we,
  input  logic [3:0]         io_be,
  input  logic [31:0]        io_wdata,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_LED-1:0] led_out,
  output logic               irq
);

  logic               hit;
  logic [2:0]         off;
  logic [31:0]        mask, wbits;
  logic [NUM_LED-1:0] led_q, led_d;
  logic [NUM_BTN-1:0] edge_q, edge_d, ie_q, ie_d;
  logic [NUM_BTN-1:0] btn_lvl, btn_rise;
  logic               irq_q;
  logic               unused_wr;

  assign hit       = (io_addr[29:3] == BASE_ADDR[31:5]);
  assign off       = io_addr[2:0];
  assign mask      = be_mask(io_be);
  assign wbits     = io_wdata & mask;
  assign unused_wr = ^{wbits, mask};

  rv32_btn_debounce #(
    .WIDTH        (NUM_BTN),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_deb (
    .clk   (clk),
    .reset (reset),
    .d_in  (btn_in),
    .level (btn_lvl),
    .rise  (btn_rise)
  );

  // Rise is ORed in after the W1C clear so a coincident set wins.
  always_comb begin
    led_d  = led_q;
    edge_d = edge_q;
    ie_d   = ie_q;
    if (io_we && hit) begin
      case (off)
        GPIO_LED_OUT:  led_d  = (led_q & ~mask[NUM_LED-1:0]) | wbits[NUM_LED-1:0];
        GPIO_LED_TGL:  led_d  = led_q ^ wbits[NUM_LED-1:0];
        GPIO_BTN_EDGE: edge_d = edge_q & ~wbits[NUM_BTN-1:0];
        GPIO_BTN_IE:   ie_d   = (ie_q & ~mask[NUM_BTN-1:0]) | wbits[NUM_BTN-1:0];
        default: ;
      endcase
    end
    edge_d = edge_d | btn_rise;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q  <= LED_RST;
      edge_q <= '0;
      ie_q   <= '0;
      irq_q  <= 1'b0;
    end else begin
      led_q  <= led_d;
      edge_q <= edge_d;
      ie_q   <= ie_d;
      irq_q  <= |(edge_q & ie_q);
    end
  end

  always_comb begin
    io_rdata = '0;
    if (hit) begin
      case (off)
        GPIO_LED_OUT:  io_rdata[NUM_LED-1:0] = led_q;
        GPIO_BTN_LVL:  io_rdata[NUM_BTN-1:0] = btn_lvl;
        GPIO_BTN_EDGE: io_rdata[NUM_BTN-1:0] = edge_q;
        GPIO_BTN_IE:   io_rdata[NUM_BTN-1:0] = ie_q;
        default: ;
      endcase
    end
  end

  assign led_out = led_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_rv32_gpio_io.sv
// Scoreboard bench for rv32_gpio_io: a main 8-LED/4-button instance and a
// 3-LED/1-button instance sharing the bus, checked against a behavioural model.
module tb_rv32_gpio_io;

  localparam int unsigned D = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] io_addr;
  logic [31:0] io_rdata, io_rdata3;
  logic        io_we;
  logic [3:0]  io_be;
  logic [31:0] io_wdata;
  logic [3:0]  btn_in;
  logic [7:0]  led_out;
  logic [2:0]  led3;
  logic        irq, irq3;
  logic        done = 1'b0;

  always #5 clk = ~clk;

  rv32_gpio_io #(
    .BASE_ADDR (32'h8000_0000), .NUM_LED (8), .NUM_BTN (4),
    .DEBOUNCE_CYC (16'd8), .LED_RST (8'h3C)
  ) dut (
    .clk (clk), .reset (reset), .io_addr (io_addr), .io_rdata (io_rdata),
    .io_we (io_we), .io_be (io_be), .io_wdata (io_wdata),
    .btn_in (btn_in), .led_out (led_out), .irq (irq)
  );

  rv32_gpio_io #(
    .BASE_ADDR (32'h8000_0000), .NUM_LED (3), .NUM_BTN (1),
    .DEBOUNCE_CYC (16'd8), .LED_RST (3'b101)
  ) dut3 (
    .clk (clk), .reset (reset), .io_addr (io_addr), .io_rdata (io_rdata3),
    .io_we (io_we), .io_be (io_be), .io_wdata (io_wdata),
    .btn_in (btn_in[0:0]), .led_out (led3), .irq (irq3)
  );

  // ---------------- reference model ----------------
  logic [7:0] led_m;
  logic [2:0] led3_m;
  logic [3:0] lvl_m, edge_m, ie_m;
  logic       irq_m;
  logic [3:0] hist[$];

  function automatic bit mhit(input logic [29:0] a);
    logic [31:0] b;
    b = {a, 2'b00};
    return (b & 32'hFFFF_FFE0) == 32'h8000_0000;
  endfunction

  function automatic logic [29:0] wa(input int unsigned off);
    logic [31:0] b;
    b = 32'h8000_0000 + off * 4;
    return b[31:2];
  endfunction

  task automatic model_init();
    led_m = 8'h3C; led3_m = 3'b101;
    lvl_m = '0; edge_m = '0; ie_m = '0; irq_m = 1'b0;
    hist.delete();
    for (int i = 0; i < int'(D) + 2; i++) hist.push_back(4'b0);
  endtask

  // A level is accepted once the last D synchronised samples (raw pin two
  // edges ago and earlier) all disagree with the currently accepted level.
  task automatic model_step();
    logic [3:0]  nlvl, rise, clr;
    logic [31:0] m, wb;
    bit          all;
    hist.push_back(btn_in);
    if (hist.size() > D + 2) void'(hist.pop_front());
    nlvl = lvl_m;
    for (int b = 0; b < 4; b++) begin
      all = 1'b1;
      for (int i = 0; i < int'(D); i++) if (hist[i][b] == lvl_m[b]) all = 1'b0;
      if (all) nlvl[b] = ~lvl_m[b];
    end
    rise  = nlvl & ~lvl_m;
    irq_m = |(edge_m & ie_m);
    clr   = '0;
    m     = {{8{io_be[3]}}, {8{io_be[2]}}, {8{io_be[1]}}, {8{io_be[0]}}};
    wb    = io_wdata & m;
    if (io_we && mhit(io_addr)) begin
      case (io_addr[2:0])
        3'd0: begin led_m = (led_m & ~m[7:0]) | wb[7:0]; led3_m = (led3_m & ~m[2:0]) | wb[2:0]; end
        3'd1: begin led_m = led_m ^ wb[7:0]; led3_m = led3_m ^ wb[2:0]; end
        3'd3: clr = wb[3:0];
        3'd4: ie_m = (ie_m & ~m[3:0]) | wb[3:0];
        default: ;
      endcase
    end
    edge_m = (edge_m & ~clr) | rise;
    lvl_m  = nlvl;
  endtask

  function automatic logic [31:0] mread(input logic [29:0] a, input bit three);
    logic [31:0] r;
    r = '0;
    if (mhit(a)) begin
      case (a[2:0])
        3'd0: r = three ? {29'b0, led3_m} : {24'b0, led_m};
        3'd2: r = three ? {31'b0, lvl_m[0]}  : {28'b0, lvl_m};
        3'd3: r = three ? {31'b0, edge_m[0]} : {28'b0, edge_m};
        3'd4: r = three ? {31'b0, ie_m[0]}   : {28'b0, ie_m};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  initial begin
    model_init();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_init();
      else        model_step();
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    int          sel;   // 0 rdata, 1 rdata3, 2 led_out, 3 led3, 4 irq
    logic [31:0] exp;
  } chk_t;

  chk_t sb[$];
  int   nchk = 0;
  int   nerr = 0;

  task automatic expect_v(input string name, input int sel, input logic [31:0] exp);
    chk_t c;
    c.name = name; c.sel = sel; c.exp = exp;
    sb.push_back(c);
  endtask

  task automatic check_now(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() != 0) begin
        c = sb.pop_front();
        case (c.sel)
          0:       act = io_rdata;
          1:       act = io_rdata3;
          2:       act = {24'b0, led_out};
          3:       act = {29'b0, led3};
          default: act = {31'b0, irq};
        endcase
        nchk++;
        if (act !== c.exp) begin
          nerr++;
          $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
        end
      end
    end
  end

  initial begin
    #500000;
    if (!done) begin
      nerr++;
      $display("FAIL timeout: stimulus did not complete");
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] be);
    io_addr = a; io_we = 1'b1; io_be = be; io_wdata = d;
    step();
    io_we = 1'b0; io_be = 4'b0;
  endtask

  task automatic rd(input logic [29:0] a, input string name);
    io_addr = a;
    expect_v(name, 0, mread(a, 1'b0));
    expect_v({name, "_n3"}, 1, mread(a, 1'b1));
    step();
  endtask

  task automatic rd_const(input logic [29:0] a, input string name, input logic [31:0] exp);
    io_addr = a;
    expect_v(name, 0, exp);
    step();
  endtask

  initial begin
    reset = 1'b0; io_addr = '0; io_we = 1'b0; io_be = '0; io_wdata = '0; btn_in = '0;
    repeat (3) step();
    reset = 1'b1;

    // reset state
    check_now("rst_led_now", {24'b0, led_out}, 32'h3C);
    expect_v("rst_led", 2, 32'h3C);
    expect_v("rst_irq", 4, 32'h0);
    expect_v("rst_led3", 3, 32'h5);
    rd_const(wa(3), "rst_edge", 32'h0);

    // LED byte writes and toggles
    wr(wa(0), 32'h0000_00A5, 4'b0001);
    expect_v("led_a5", 2, 32'hA5);
    rd(wa(0), "rd_led_a5");
    wr(wa(1), 32'h0000_000F, 4'b0001);
    expect_v("led_tgl", 2, 32'hAA);
    rd(wa(1), "rd_tgl_zero");
    wr(wa(0), 32'hFFFF_FFFF, 4'b0000);
    expect_v("led_be0", 2, 32'hAA);
    step();
    wr(wa(0), 32'hFFFF_FFFF, 4'b1110);
    rd_const(wa(0), "led_be_hi", 32'hAA);
    rd(wa(0), "rd_led3_tgl");

    // short glitch is rejected
    btn_in[1] = 1'b1;
    repeat (5) step();
    btn_in[1] = 1'b0;
    for (int i = 0; i < 14; i++) rd_const(wa(2), "lvl_glitch", 32'h0);

    // sustained press accepted after 2+D cycles
    btn_in[1] = 1'b1;
    repeat (9) step();
    rd_const(wa(2), "lvl_pre", 32'h0);
    rd_const(wa(2), "lvl_rise", 32'h2);
    rd_const(wa(3), "edge_rise", 32'h2);
    btn_in[1] = 1'b0;

    // irq follows enable and W1C one cycle later
    wr(wa(4), 32'h2, 4'b0001);
    expect_v("irq_pre", 4, 32'h0);
    step();
    expect_v("irq_set", 4, 32'h1);
    step();
    wr(wa(3), 32'h2, 4'b0001);
    expect_v("irq_hold", 4, 32'h1);
    rd_const(wa(3), "edge_clr", 32'h0);
    expect_v("irq_clr", 4, 32'h0);
    repeat (12) step();
    rd_const(wa(3), "no_fall_edge", 32'h0);
    rd_const(wa(2), "lvl_released", 32'h0);

    // W1C coincident with a debounced rise: set wins
    btn_in[1] = 1'b1;
    repeat (9) step();
    wr(wa(3), 32'h2, 4'b0001);
    rd_const(wa(3), "set_wins", 32'h2);
    wr(wa(3), 32'hF, 4'b0001);
    rd_const(wa(3), "edge_w1c", 32'h0);
    btn_in[1] = 1'b0;
    repeat (12) step();

    // unmapped offsets and out-of-window address
    for (int unsigned o = 5; o <= 8; o++) wr(wa(o), 32'hFFFF_FFFF, 4'hF);
    for (int unsigned o = 5; o <= 8; o++) rd_const(wa(o), "miss_rd", 32'h0);
    expect_v("miss_led", 2, 32'hAA);
    rd_const(wa(4), "miss_ie", 32'h2);
    wr(wa(0), 32'hFFFF_FFFF, 4'hF);
    io_addr = wa(0);
    expect_v("led_full", 0, 32'hFF);
    expect_v("led3_full", 1, 32'h7);
    step();

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) btn_in = btn_in ^ (4'b1 << $urandom_range(0, 3));
      io_addr  = wa($urandom_range(0, 8));
      io_we    = ($urandom_range(0, 2) == 0);
      io_be    = 4'($urandom);
      io_wdata = $urandom;
      expect_v("rnd_rdata", 0, mread(io_addr, 1'b0));
      expect_v("rnd_rdata3", 1, mread(io_addr, 1'b1));
      expect_v("rnd_led", 2, {24'b0, led_m});
      expect_v("rnd_led3", 3, {29'b0, led3_m});
      expect_v("rnd_irq", 4, {31'b0, irq_m});
      step();
    end
    io_we = 1'b0; io_be = '0;

    // mid-run reset with a button held through release
    wr(wa(4), 32'hF, 4'b0001);
    wr(wa(0), 32'h5A, 4'b0001);
    btn_in = 4'b0100;
    repeat (12) step();
    reset = 1'b0;
    #1;
    io_addr = wa(3);
    #1;
    check_now("mid_rst_led_now", {24'b0, led_out}, 32'h3C);
    check_now("mid_rst_irq_now", {31'b0, irq}, 32'h0);
    check_now("mid_rst_led3_now", {29'b0, led3}, 32'h5);
    check_now("mid_rst_edge_now", io_rdata, 32'h0);
    expect_v("mid_rst_led", 2, 32'h3C);
    expect_v("mid_rst_irq", 4, 32'h0);
    expect_v("mid_rst_edge", 0, 32'h0);
    step();
    rd_const(wa(4), "mid_rst_ie", 32'h0);
    reset = 1'b1;
    repeat (9) step();
    rd_const(wa(2), "held_lvl_pre", 32'h0);
    rd_const(wa(3), "held_edge", 32'h4);
    rd(wa(2), "held_lvl");

    @(negedge clk);
    #1;
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
